arm_mul_unit: RTL and testbench



---
 rtl/arm_mul_unit_if.sv | 33 +++
 rtl/arm_mul_unit.sv | 120 ++++++++++++
 tb/tb_arm_mul_unit.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_mul_unit_if.sv
// Multiply unit request/response bundle.
//   start, long_mode, signed_mode, accumulate : request and mode bits
//   a, b, acc                                 : multiplicand, multiplier, accumulate addend
//   busy, done                                : operation status (done is a one-cycle pulse)
//   result_lo, result_hi, flag_n, flag_z      : registered result and N/Z flags
// master: controller side; slave: multiply unit side.
interface arm_mul_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic                 long_mode;
  logic                 signed_mode;
  logic                 accumulate;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   acc;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result_lo;
  logic [WIDTH-1:0]     result_hi;
  logic                 flag_n;
  logic                 flag_z;

  modport master (
    output start, long_mode, signed_mode, accumulate, a, b, acc,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, long_mode, signed_mode, accumulate, a, b, acc,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

// File: rtl/arm_mul_unit.sv
// Iterative multiply / multiply-accumulate unit for the multicycle ARM core.
// Retires STEP multiplier bits per cycle over N = WIDTH/STEP cycles, then spends one
// cycle applying sign correction and the accumulate addend.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : arm_mul_unit_if slave (request, operands, status, results, N/Z flags)
module arm_mul_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input logic          clk,
  input logic          reset,
  arm_mul_unit_if.slave bus
);

  localparam int unsigned N    = WIDTH / STEP;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned PW   = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     a_sh_q;     // multiplicand magnitude, shifted left as bits retire
  logic [WIDTH-1:0]  b_q;        // multiplier magnitude, shifted right as bits retire
  logic [PW-1:0]     acc_q;      // addend, pre-masked to the low word in short mode
  logic [PW-1:0]     prod_q;
  logic [CntW-1:0]   cnt_q;
  logic              long_q;
  logic              accum_q;
  logic              sign_q;     // negate in FIX; only ever set for signed long
  logic [WIDTH-1:0]  result_lo_q, result_hi_q;
  logic              flag_n_q, flag_z_q;

  logic              start_ok;
  logic              signed_long;
  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [PW-1:0]     step_sum;
  logic [PW-1:0]     prod_fixed;
  logic [PW-1:0]     fix_sum;
  logic [PW-1:0]     final_res;

  assign start_ok    = bus.start && (state_q == StIdle || state_q == StDone);
  assign signed_long = bus.signed_mode && bus.long_mode;

  // Negating -2^(WIDTH-1) wraps to the same bit pattern, which read as unsigned
  // is exactly the magnitude 2^(WIDTH-1), so WIDTH bits suffice.
  assign a_abs = (signed_long && bus.a[WIDTH-1]) ? (WIDTH'(0) - bus.a) : bus.a;
  assign b_abs = (signed_long && bus.b[WIDTH-1]) ? (WIDTH'(0) - bus.b) : bus.b;

  always_comb begin
    step_sum = '0;
    for (int i = 0; i < STEP; i++) begin
      if (b_q[i]) step_sum = step_sum + (a_sh_q << i);
    end
  end

  assign prod_fixed = sign_q ? (PW'(0) - prod_q) : prod_q;
  assign fix_sum    = prod_fixed + (accum_q ? acc_q : PW'(0));
  assign final_res  = long_q ? fix_sum : {{WIDTH{1'b0}}, fix_sum[WIDTH-1:0]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (cnt_q == CntW'(1)) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = bus.start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      long_q      <= 1'b0;
      accum_q     <= 1'b0;
      sign_q      <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        a_sh_q  <= {{WIDTH{1'b0}}, a_abs};
        b_q     <= b_abs;
        acc_q   <= bus.long_mode ? bus.acc : {{WIDTH{1'b0}}, bus.acc[WIDTH-1:0]};
        prod_q  <= '0;
        cnt_q   <= CntW'(N);
        long_q  <= bus.long_mode;
        accum_q <= bus.accumulate;
        sign_q  <= signed_long && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      end else if (state_q == StRun) begin
        prod_q <= prod_q + step_sum;
        a_sh_q <= a_sh_q << STEP;
        b_q    <= b_q >> STEP;
        cnt_q  <= cnt_q - CntW'(1);
      end else if (state_q == StFix) begin
        result_lo_q <= final_res[WIDTH-1:0];
        result_hi_q <= final_res[PW-1:WIDTH];
        flag_n_q    <= long_q ? final_res[PW-1] : final_res[WIDTH-1];
        flag_z_q    <= (final_res == '0);
      end
    end
  end

  assign bus.busy      = (state_q == StRun) || (state_q == StFix);
  assign bus.done      = (state_q == StDone);
  assign bus.result_lo = result_lo_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;

endmodule

// File: tb/tb_arm_mul_unit.sv
module tb_arm_mul_unit;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  arm_mul_unit_if #(.WIDTH(32)) bus1 ();
  arm_mul_unit_if #(.WIDTH(32)) bus4 ();

  arm_mul_unit #(.WIDTH(32), .STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  arm_mul_unit #(.WIDTH(32), .STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width arithmetic, then truncation to the mode's result width.
  function automatic exp_t model(input logic lm, input logic sm, input logic ac,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] acc);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    exp_t e;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (lm && sm) p = sa * sb;
    else          p = {32'b0, a} * {32'b0, b};
    if (ac) p = lm ? p + acc : p + {32'b0, acc[31:0]};
    if (!lm) p = {32'b0, p[31:0]};
    e.lo = p[31:0];
    e.hi = p[63:32];
    e.n  = lm ? p[63] : p[31];
    e.z  = (p == 64'b0);
    return e;
  endfunction

  int          busy_cnt;
  bit          got_done;
  logic [31:0] o_lo, o_hi;
  logic        o_n, o_z;
  exp_t        e;

  // Drive one operation on the STEP=1 unit and wait (bounded) for done.
  task automatic do_op(input logic lm, input logic sm, input logic ac,
                       input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc);
    @(negedge clk);
    bus1.long_mode = lm; bus1.signed_mode = sm; bus1.accumulate = ac;
    bus1.a = a; bus1.b = b; bus1.acc = acc; bus1.start = 1'b1;
    sb_q.push_back(model(lm, sm, ac, a, b, acc));
    @(negedge clk);
    bus1.start = 1'b0;
    busy_cnt = 0; got_done = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus1.done) begin
        o_lo = bus1.result_lo; o_hi = bus1.result_hi; o_n = bus1.flag_n; o_z = bus1.flag_z;
        got_done = 1;
        break;
      end
      if (bus1.busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic pop_exp(input string name);
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      e = '{lo: 32'hx, hi: 32'hx, n: 1'bx, z: 1'bx};
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus1.busy, bus1.done, bus1.result_lo, bus1.result_hi, bus1.flag_n, bus1.flag_z} !== '0) begin
      errors++;
      $display("FAIL reset_step1: got busy=%b done=%b lo=%h hi=%h n=%b z=%b want all 0",
               bus1.busy, bus1.done, bus1.result_lo, bus1.result_hi, bus1.flag_n, bus1.flag_z);
    end
    checks++;
    if ({bus4.busy, bus4.done, bus4.result_lo, bus4.result_hi, bus4.flag_n, bus4.flag_z} !== '0) begin
      errors++;
      $display("FAIL reset_step4: got busy=%b done=%b lo=%h hi=%h want all 0",
               bus4.busy, bus4.done, bus4.result_lo, bus4.result_hi);
    end
    reset = 1'b1;
  endtask

  task automatic test_short_mul;
    do_op(1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 64'd0);
    pop_exp("short_mul");
    checks++;
    if (!got_done) begin errors++; $display("FAIL short_mul_done: got timeout want done"); end
    checks++;
    if (busy_cnt !== 33) begin
      errors++; $display("FAIL short_mul_busy: got %0d cycles want 33", busy_cnt);
    end
    checks++;
    if ({o_hi, o_lo, o_n, o_z} !== {e.hi, e.lo, e.n, e.z}) begin
      errors++;
      $display("FAIL short_mul_result: got %h_%h n=%b z=%b want %h_%h n=%b z=%b",
               o_hi, o_lo, o_n, o_z, e.hi, e.lo, e.n, e.z);
    end
    @(negedge clk);
    checks++;
    if (bus1.done !== 1'b0 || bus1.result_lo !== 32'd42) begin
      errors++;
      $display("FAIL short_mul_pulse: got done=%b lo=%h want done=0 lo=0000002a",
               bus1.done, bus1.result_lo);
    end
  endtask

  task automatic test_fixed_ops;
    logic        lm[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        sm[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        ac[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] av[4] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd3};
    logic [31:0] bv[4] = '{32'h00000002, 32'h80000000, 32'hFFFFFFFF, 32'd5};
    logic [63:0] cv[4] = '{64'd0, 64'd0, 64'h00000001_FFFFFFFF, 64'h00000000_FFFFFFF1};
    // Independently worked expected values for the corner operands.
    logic [65:0] want[4] = '{{64'hFFFFFFFF_FFFFFFFE, 1'b1, 1'b0},
                             {64'h40000000_00000000, 1'b0, 1'b0},
                             {64'h00000000_00000000, 1'b0, 1'b1},
                             {64'h00000000_00000000, 1'b0, 1'b1}};
    for (int k = 0; k < 4; k++) begin
      do_op(lm[k], sm[k], ac[k], av[k], bv[k], cv[k]);
      pop_exp("fixed");
      checks++;
      if (!got_done || {o_hi, o_lo, o_n, o_z} !== want[k]) begin
        errors++;
        $display("FAIL fixed_op%0d: got done=%b %h_%h n=%b z=%b want %h", k, got_done,
                 o_hi, o_lo, o_n, o_z, want[k]);
      end
      checks++;
      if ({o_hi, o_lo, o_n, o_z} !== {e.hi, e.lo, e.n, e.z}) begin
        errors++;
        $display("FAIL fixed_model%0d: got %h_%h want %h_%h", k, o_hi, o_lo, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      do_op(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
            {$urandom, $urandom});
      pop_exp("random");
      checks++;
      if (!got_done || {o_hi, o_lo, o_n, o_z} !== {e.hi, e.lo, e.n, e.z}) begin
        errors++;
        $display("FAIL random%0d: got done=%b %h_%h n=%b z=%b want %h_%h n=%b z=%b", k,
                 got_done, o_hi, o_lo, o_n, o_z, e.hi, e.lo, e.n, e.z);
      end
    end
  endtask

  task automatic test_ignore_start;
    @(negedge clk);
    bus1.long_mode = 1'b1; bus1.signed_mode = 1'b1; bus1.accumulate = 1'b0;
    bus1.a = 32'hFFFF1234; bus1.b = 32'h00056789; bus1.acc = 64'd0; bus1.start = 1'b1;
    sb_q.push_back(model(1'b1, 1'b1, 1'b0, 32'hFFFF1234, 32'h00056789, 64'd0));
    @(negedge clk);
    bus1.start = 1'b0;
    busy_cnt = 0; got_done = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 3) begin
        bus1.a = 32'd9; bus1.b = 32'd11; bus1.long_mode = 1'b0; bus1.start = 1'b1;
      end
      if (i == 4) bus1.start = 1'b0;
      if (i == 12) begin bus1.accumulate = 1'b1; bus1.acc = 64'hFFFF; bus1.start = 1'b1; end
      if (i == 13) bus1.start = 1'b0;
      if (bus1.done) begin
        o_lo = bus1.result_lo; o_hi = bus1.result_hi; o_n = bus1.flag_n; o_z = bus1.flag_z;
        got_done = 1;
        break;
      end
      if (bus1.busy) busy_cnt++;
      @(negedge clk);
    end
    pop_exp("ignore_start");
    checks++;
    if (busy_cnt !== 33) begin
      errors++; $display("FAIL ignore_start_busy: got %0d cycles want 33", busy_cnt);
    end
    checks++;
    if (!got_done || {o_hi, o_lo, o_n, o_z} !== {e.hi, e.lo, e.n, e.z}) begin
      errors++;
      $display("FAIL ignore_start_result: got %h_%h n=%b z=%b want %h_%h n=%b z=%b",
               o_hi, o_lo, o_n, o_z, e.hi, e.lo, e.n, e.z);
    end
  endtask

  task automatic test_reset_abort;
    int done_seen;
    @(negedge clk);
    bus1.long_mode = 1'b1; bus1.signed_mode = 1'b0; bus1.accumulate = 1'b0;
    bus1.a = 32'd100; bus1.b = 32'd100; bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus1.busy, bus1.done, bus1.result_lo, bus1.result_hi, bus1.flag_n, bus1.flag_z} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b lo=%h hi=%h n=%b z=%b want all 0",
               bus1.busy, bus1.done, bus1.result_lo, bus1.result_hi, bus1.flag_n, bus1.flag_z);
    end
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.done || bus1.busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", done_seen);
    end
    do_op(1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 64'd0);
    pop_exp("after_abort");
    checks++;
    if (!got_done || o_lo !== 32'd6 || o_lo !== e.lo || o_hi !== 32'd0) begin
      errors++;
      $display("FAIL after_abort: got done=%b lo=%h hi=%h want lo=00000006 hi=0", got_done,
               o_lo, o_hi);
    end
  endtask

  task automatic test_back_to_back;
    int   cnt2;
    logic first_busy;
    @(negedge clk);
    bus4.long_mode = 1'b1; bus4.signed_mode = 1'b1; bus4.accumulate = 1'b1;
    bus4.a = 32'h80000000; bus4.b = 32'h7FFFFFFF; bus4.acc = 64'h12345678_9ABCDEF0;
    bus4.start = 1'b1;
    sb_q.push_back(model(1'b1, 1'b1, 1'b1, 32'h80000000, 32'h7FFFFFFF, 64'h12345678_9ABCDEF0));
    @(negedge clk);
    bus4.start = 1'b0;
    busy_cnt = 0; got_done = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus4.done) begin
        o_lo = bus4.result_lo; o_hi = bus4.result_hi; o_n = bus4.flag_n; o_z = bus4.flag_z;
        got_done = 1;
        break;
      end
      if (bus4.busy) busy_cnt++;
      @(negedge clk);
    end
    // Issue the next op while done is high.
    bus4.long_mode = 1'b0; bus4.signed_mode = 1'b0; bus4.accumulate = 1'b1;
    bus4.a = 32'hDEADBEEF; bus4.b = 32'h00C0FFEE; bus4.acc = 64'hFFFFFFFF_00000055;
    bus4.start = got_done;
    pop_exp("b2b_first");
    checks++;
    if (busy_cnt !== 9) begin
      errors++; $display("FAIL b2b_busy1: got %0d cycles want 9", busy_cnt);
    end
    checks++;
    if (!got_done || {o_hi, o_lo, o_n, o_z} !== {e.hi, e.lo, e.n, e.z}) begin
      errors++;
      $display("FAIL b2b_result1: got done=%b %h_%h n=%b z=%b want %h_%h n=%b z=%b",
               got_done, o_hi, o_lo, o_n, o_z, e.hi, e.lo, e.n, e.z);
    end
    sb_q.push_back(model(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h00C0FFEE, 64'hFFFFFFFF_00000055));
    @(negedge clk);
    bus4.start = 1'b0;
    first_busy = bus4.busy;
    cnt2 = 0; got_done = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus4.done) begin
        o_lo = bus4.result_lo; o_hi = bus4.result_hi; o_n = bus4.flag_n; o_z = bus4.flag_z;
        got_done = 1;
        break;
      end
      if (bus4.busy) cnt2++;
      @(negedge clk);
    end
    pop_exp("b2b_second");
    checks++;
    if (first_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_no_idle: got busy=%b after done want 1", first_busy);
    end
    checks++;
    if (cnt2 !== 9) begin
      errors++; $display("FAIL b2b_busy2: got %0d cycles want 9", cnt2);
    end
    checks++;
    if (!got_done || {o_hi, o_lo, o_n, o_z} !== {e.hi, e.lo, e.n, e.z}) begin
      errors++;
      $display("FAIL b2b_result2: got done=%b %h_%h n=%b z=%b want %h_%h n=%b z=%b",
               got_done, o_hi, o_lo, o_n, o_z, e.hi, e.lo, e.n, e.z);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus1.start = 1'b0; bus1.long_mode = 1'b0; bus1.signed_mode = 1'b0; bus1.accumulate = 1'b0;
    bus1.a = '0; bus1.b = '0; bus1.acc = '0;
    bus4.start = 1'b0; bus4.long_mode = 1'b0; bus4.signed_mode = 1'b0; bus4.accumulate = 1'b0;
    bus4.a = '0; bus4.b = '0; bus4.acc = '0;
    test_reset();
    test_short_mul();
    test_fixed_ops();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
